// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: issues one req/gnt/rsp transaction per
// load/store, holds the pipeline while it is in flight, aligns store lanes and
// extracts/extends load data into mem_data for the MEM/WB register.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] mem_data,
    output logic        req,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    input  logic        gnt,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lo_q;
    logic [2:0]       f3_q;

    logic             access;
    logic             is_half;
    logic             is_word;
    logic             start;
    logic [31:0]      st_data;
    logic [3:0]       st_be;
    logic [31:0]      shifted;
    logic [31:0]      ld_val;

    // Access decode, misalignment trap flag, start and pipeline hold
    always_comb begin
        access   = valid & (mem_read | mem_write);
        is_half  = (funct3[1:0] == 2'b01);
        is_word  = funct3[1];
        misalign = access & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
        start    = rst & access & ~misalign & (state == IDLE);
        stall    = start | (rst & ((state == REQ) | (state == WAIT_RSP)));
    end

    // Store lane replication and byte enables from size and address offset
    always_comb begin
        st_data = wdata;
        st_be   = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_data = {4{wdata[7:0]}};
                st_be   = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_data = {2{wdata[15:0]}};
                st_be   = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = wdata;
                st_be   = 4'b1111;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then sign/zero extend
    always_comb begin
        shifted = rsp_rdata >> {lo_q, 3'b000};
        ld_val  = shifted;
        case (f3_q)
            3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_val = {24'h00_0000, shifted[7:0]};
            3'b101:  ld_val = {16'h0000, shifted[15:0]};
            default: ld_val = shifted;
        endcase
    end

    // Transaction FSM with registered request, result and error outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lo_q      <= 2'b00;
            f3_q      <= 3'b000;
            req       <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= 32'h0;
            req_wdata <= 32'h0;
            req_be    <= 4'h0;
            mem_data  <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REQ;
                        req       <= 1'b1;
                        // A simultaneous read and write is treated as a load
                        req_we    <= mem_write & ~mem_read;
                        req_addr  <= {addr[31:2], 2'b00};
                        req_wdata <= st_data;
                        req_be    <= st_be;
                        lo_q      <= addr[1:0];
                        f3_q      <= funct3;
                    end
                end
                REQ: begin
                    if (gnt) begin
                        state <= WAIT_RSP;
                        req   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_valid) begin
                        state <= DONE;
                        if (!req_we) begin
                            mem_data <= ld_val;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state    <= DONE;
                        bus_err  <= 1'b1;
                        mem_data <= 32'h0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver issues load/store ops and a
// memory responder answers with configurable gnt/rsp latency; expected
// requests and results are queued and checked by an independent monitor.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          chk_be;
        bit          chk_wd;
    } exp_req_t;

    typedef struct {
        logic [31:0] md;
        logic        berr;
    } exp_res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, misalign, bus_err;
    logic [31:0] mem_data;
    logic        req, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        gnt, rsp_valid;
    logic [31:0] rsp_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_berr   = 0;
    int          exp_berr = 0;
    logic [31:0] model_md = 32'h0;

    int          cfg_gnt_lat = 0;
    int          cfg_rsp_lat = 0;
    bit          cfg_drop    = 1'b0;
    bit          cfg_early   = 1'b0;
    bit          stale_on    = 1'b0;
    logic [31:0] cfg_rdata   = 32'h0;

    exp_req_t    exp_req_q[$];
    exp_res_t    exp_res_q[$];

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .misalign(misalign), .bus_err(bus_err),
        .mem_data(mem_data), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Load result from the architectural rules: pick the lane, then extend
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
        int unsigned n;
        logic [31:0] v;
        n = 32'd1 << f3[1:0];
        v = d >> (8 * (a % 4));
        if (n < 4) begin
            v = v & ((32'd1 << (8 * n)) - 32'd1);
            if (!f3[2] && v >= (32'd1 << (8 * n - 1)))
                v = v - (32'd1 << (8 * n));
        end
        return v;
    endfunction

    // Memory responder: grants after cfg_gnt_lat, answers after cfg_rsp_lat
    initial begin
        int phase;
        int cnt;
        phase = 0;
        cnt = 0;
        gnt = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            gnt = 1'b0;
            rsp_valid = 1'b0;
            rsp_rdata = $urandom();
            if (!rst) begin
                phase = 0;
                cnt = 0;
            end else if (stale_on) begin
                rsp_valid = 1'b1;
                rsp_rdata = cfg_rdata;
            end else if (phase == 0) begin
                if (req) begin
                    if (cnt == cfg_gnt_lat) begin
                        gnt = 1'b1;
                        if (cfg_early) rsp_valid = 1'b1;
                        cnt = 0;
                        phase = cfg_drop ? 0 : 1;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                if (cnt == cfg_rsp_lat) begin
                    rsp_valid = 1'b1;
                    rsp_rdata = cfg_rdata;
                    cnt = 0;
                    phase = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: checks every presented request and every completion
    initial begin
        bit       in_flight;
        exp_req_t er;
        exp_res_t rs;
        in_flight = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                in_flight = 1'b0;
            end else begin
                if (bus_err) n_berr++;
                if (req) begin
                    check32("req_pending", 32'(exp_req_q.size() != 0), 32'd1);
                    if (exp_req_q.size() != 0) begin
                        er = exp_req_q[0];
                        check32("req_we", 32'(req_we), 32'(er.we));
                        check32("req_addr", req_addr, er.addr);
                        if (er.chk_be) check32("req_be", 32'(req_be), 32'(er.be));
                        if (er.chk_wd) check32("req_wdata", req_wdata, er.wdata);
                        if (gnt) begin
                            er = exp_req_q.pop_front();
                            in_flight = 1'b1;
                        end
                    end
                end else if (in_flight && !stall) begin
                    check32("res_pending", 32'(exp_res_q.size() != 0), 32'd1);
                    if (exp_res_q.size() != 0) begin
                        rs = exp_res_q.pop_front();
                        check32("mem_data", mem_data, rs.md);
                        check32("bus_err", 32'(bus_err), 32'(rs.berr));
                    end
                    in_flight = 1'b0;
                end
            end
        end
    end

    task automatic recover_reset();
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_req_q.delete();
        exp_res_q.delete();
        model_md = 32'h0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, queue its expectations, and follow it to completion
    task automatic run_op(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int gl,
                          input int rl, input bit drop, input bit early,
                          input logic [31:0] rdat);
        int unsigned n;
        int unsigned off;
        int          stall_cyc;
        int          exp_stall;
        bit          acc;
        bit          mis;
        exp_req_t    er;
        exp_res_t    rs;
        n   = 32'd1 << f3[1:0];
        off = a % 4;
        acc = v && (rd || wr);
        mis = acc && ((a % n) != 0);
        cfg_gnt_lat = gl; cfg_rsp_lat = rl; cfg_drop = drop; cfg_early = early;
        cfg_rdata = rdat;
        valid = v; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        if (acc && !mis) begin
            er.we = wr && !rd;
            er.addr = a - (a % 4);
            er.chk_wd = er.we;
            er.chk_be = er.we || (n == 4);
            if (n == 1) begin
                er.wdata = (wd & 32'hFF) * 32'h0101_0101;
                er.be = 4'(32'd1 << off);
            end else if (n == 2) begin
                er.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
                er.be = 4'(32'd3 << off);
            end else begin
                er.wdata = wd;
                er.be = 4'hF;
            end
            exp_req_q.push_back(er);
            if (drop) begin
                model_md = 32'h0;
                rs.berr = 1'b1;
                exp_berr++;
            end else begin
                if (!er.we) model_md = load_val(f3, a, rdat);
                rs.berr = 1'b0;
            end
            rs.md = model_md;
            exp_res_q.push_back(rs);
        end
        @(negedge clk);
        #1;
        check32("misalign", 32'(misalign), 32'(mis));
        if (!acc || mis) begin
            check32("stall_noreq", 32'(stall), 32'd0);
            @(negedge clk);
            #1;
            check32("req_noreq", 32'(req), 32'd0);
        end else begin
            exp_stall = 2 + gl + (drop ? int'(TO) : rl + 1);
            stall_cyc = 0;
            for (int i = 0; i < 64 && stall; i++) begin
                stall_cyc++;
                @(negedge clk);
                #1;
            end
            check32("stall_cycles", 32'(stall_cyc), 32'(exp_stall));
            if (stall) recover_reset();
        end
        @(posedge clk);
        #1;
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_req_t er;
        rst = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check32("rst_req", 32'(req), 32'd0);
        check32("rst_req_we", 32'(req_we), 32'd0);
        check32("rst_req_addr", req_addr, 32'h0);
        check32("rst_req_wdata", req_wdata, 32'h0);
        check32("rst_req_be", 32'(req_be), 32'd0);
        check32("rst_mem_data", mem_data, 32'h0);
        check32("rst_bus_err", 32'(bus_err), 32'd0);
        check32("rst_stall", 32'(stall), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed: zero-wait lw, lane extraction, store lanes, misaligns
        run_op(1, 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 0, 0, 32'hDEADBEEF);
        run_op(1, 1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 0, 0, 32'h80112233);
        run_op(1, 1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 0, 0, 32'h80112233);
        run_op(1, 1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 0, 0, 32'h80112233);
        run_op(1, 0, 1, 3'b000, 32'h201, 32'hAB, 0, 0, 0, 0, 32'h0);
        run_op(1, 1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 0, 0, 32'h0);
        run_op(1, 0, 1, 3'b001, 32'h003, 32'h0, 0, 0, 0, 0, 32'h0);
        // Same-cycle rsp with gnt must be ignored; rsp on the last allowed cycle
        run_op(1, 1, 0, 3'b010, 32'h104, 32'h0, 0, 2, 0, 1, 32'h11223344);
        run_op(1, 1, 0, 3'b101, 32'h106, 32'h0, 1, TO - 1, 0, 0, 32'hCAFE1234);
        // Late gnt followed by no response: timeout abort
        run_op(1, 1, 0, 3'b010, 32'h400, 32'h0, 4, 0, 1, 0, 32'h0);
        run_op(1, 1, 0, 3'b010, 32'h500, 32'h0, 0, 0, 0, 0, 32'h5555AAAA);

        // Reset in WAIT_RSP, then a stale response after release
        cfg_gnt_lat = 0; cfg_rsp_lat = 3; cfg_drop = 1'b0; cfg_early = 1'b0;
        cfg_rdata = 32'h12345678;
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
        er.we = 1'b0; er.addr = 32'h300; er.wdata = 32'h0; er.be = 4'hF;
        er.chk_be = 1'b1; er.chk_wd = 1'b0;
        exp_req_q.push_back(er);
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check32("midrst_req", 32'(req), 32'd0);
        check32("midrst_stall", 32'(stall), 32'd0);
        check32("midrst_mem_data", mem_data, 32'h0);
        @(negedge clk);
        #2;
        check32("midrst_hold_req", 32'(req), 32'd0);
        valid = 1'b0; mem_read = 1'b0;
        model_md = 32'h0;
        stale_on = 1'b1;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #2;
            check32("stale_mem_data", mem_data, 32'h0);
            check32("stale_stall", 32'(stall), 32'd0);
            check32("stale_req", 32'(req), 32'd0);
        end
        stale_on = 1'b0;
        @(posedge clk);
        #1;
        check32("stale_after_mem_data", mem_data, 32'h0);

        // Randomized ops against the reference model
        for (int k = 0; k < 80; k++) begin
            int          op;
            bit          v, rd, wr, drop, early;
            logic [2:0]  f3;
            op = $urandom_range(0, 7);
            case (op)
                0: begin f3 = 3'b000; rd = 1; wr = 0; end
                1: begin f3 = 3'b001; rd = 1; wr = 0; end
                2: begin f3 = 3'b010; rd = 1; wr = 0; end
                3: begin f3 = 3'b100; rd = 1; wr = 0; end
                4: begin f3 = 3'b101; rd = 1; wr = 0; end
                5: begin f3 = 3'b000; rd = 0; wr = 1; end
                6: begin f3 = 3'b001; rd = 0; wr = 1; end
                default: begin f3 = 3'b010; rd = 0; wr = 1; end
            endcase
            if (rd && $urandom_range(0, 9) == 0) wr = 1;
            if ($urandom_range(0, 19) == 0) begin rd = 0; wr = 0; end
            v = ($urandom_range(0, 9) != 0);
            drop = rd && ($urandom_range(0, 7) == 0);
            early = ($urandom_range(0, 4) == 0);
            run_op(v, rd, wr, f3, $urandom(), $urandom(), $urandom_range(0, 3),
                   $urandom_range(0, TO - 1), drop, early, $urandom());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(negedge clk);
        #2;
        check32("bus_err_pulses", 32'(n_berr), 32'(exp_berr));
        check32("req_q_empty", 32'(exp_req_q.size()), 32'd0);
        check32("res_q_empty", 32'(exp_res_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory access engine in the five-stage pipeline. It takes the load/store request from the EX/MEM register, runs a req/gnt/rsp handshake to a variable-latency data memory, and holds the pipeline until the access completes. Stores get byte-lane alignment; loads get extraction and sign/zero extension. It produces mem_data, the value that feeds the MEM/WB register's memory-data input.

Parameters:
TIMEOUT, 255, max cycles waited in WAIT_RSP before abort (1..255)
CNT_W, 8, width of the timeout counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
valid  input  1  EX/MEM slot holds a live instruction
mem_read  input  1  load request
mem_write  input  1  store request
funct3  input  3  size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use 000/001/010)
addr  input  32  byte address from ALU
wdata  input  32  store data (rs2)
stall  output  1  freeze IF..MEM pipeline registers
misalign  output  1  combinational misaligned-access flag
bus_err  output  1  one-cycle pulse on timeout abort
mem_data  output  32  extended load result to MEM/WB
req  output  1  memory request
req_we  output  1  1 = write
req_addr  output  32  word-aligned address (addr[1:0] forced 00)
req_wdata  output  32  lane-replicated store data
req_be  output  4  byte enables
gnt  input  1  memory accepted request
rsp_valid  input  1  memory completion (read data valid / write ack)
rsp_rdata  input  32  read data

Behaviour:
- Reset (rst low, async): state IDLE, counter 0. Outputs: req 0, req_we 0, req_addr 0, req_wdata 0, req_be 0, mem_data 0, bus_err 0, stall 0.
- start = valid & (mem_read | mem_write) & ~misalign & state==IDLE. If both mem_read and mem_write are set, the access is a load.
- misalign: valid & (mem_read|mem_write) & ((halfword & addr[0]) | (word & addr[1:0]!=0)). No request is issued and stall stays 0; the trap is handled elsewhere.
- stall = start | state in {REQ, WAIT_RSP}. stall is 0 in DONE, so the pipeline advances at the end of the DONE cycle. This prevents the held instruction from re-triggering.
- FSM:
  - IDLE -> REQ on start. At that edge, capture req_we, req_addr, req_wdata, req_be, plus addr[1:0] and funct3 for load extraction.
  - REQ: req=1, with all req_* stable until gnt. gnt -> WAIT_RSP (req drops the next cycle, counter cleared).
  - WAIT_RSP: counter increments each cycle.
    - rsp_valid -> DONE. For a load, mem_data is loaded from rsp_rdata in the same edge.
    - Counter reaching TIMEOUT without rsp_valid -> DONE, with bus_err=1 for the DONE cycle and mem_data=0.
  - DONE -> IDLE unconditionally.
- rsp_valid is ignored outside WAIT_RSP, including a stale response arriving after reset.
- Store lanes:
  - sb: wdata[7:0] replicated x4, be = 0001 << addr[1:0].
  - sh: wdata[15:0] replicated x2, be = addr[1] ? 1100 : 0011.
  - sw: be = 1111.
- Load extract: shifted = rsp_rdata >> (8*addr[1:0]).
  - lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes through.
- mem_data updates only on load completion and holds otherwise; stores do not change it.
- Minimum latency, zero-wait memory: op presented at cycle 0 (stall=1), REQ+gnt at cycle 1, rsp_valid at cycle 2, DONE at cycle 3 (stall=0). That is 4 cycles total. rsp_valid asserted in the same cycle as gnt is not accepted.
- Reset asserted mid-operation: immediate IDLE with all outputs at reset values; the in-flight access is abandoned.

Test Plan:
- lw addr=0x100, memory gnt immediate, rsp_valid 1 cycle later with rdata=0xDEADBEEF -> req_addr=0x100, be=1111, stall high for 3 cycles, mem_data=0xDEADBEEF in DONE.
- lb addr=0x103, rdata=0x80112233 -> mem_data=0xFFFFFF80; lbu at the same address -> 0x00000080; lh addr=0x102 -> 0xFFFF8011.
- sb addr=0x201, wdata=0x000000AB -> req_we=1, req_addr=0x200, req_wdata=0xABABABAB, be=0010; mem_data unchanged.
- lw addr=0x102 -> misalign=1, req never asserted, stall=0; sh addr=0x3 -> misalign=1.
- gnt delayed 5 cycles, then no rsp_valid (TIMEOUT=4) -> req held stable for 5 cycles, bus_err pulses once, mem_data=0, FSM returns to IDLE.
- rst low during WAIT_RSP, then a stale rsp_valid after release -> req=0 and stall=0 immediately on reset; the stale response is ignored and mem_data stays 0.
